alu_ctrl_exec: RTL
==================

Name: alu_ctrl_exec

Overview:
- Parametrised, registered successor to the EX-stage ALU control decoder.
- Decodes ALUop/functionCode to an operation code and executes it on WIDTH-bit operands.
- Single-cycle ops complete in one clock; MUL runs as a multi-cycle shift-add sequence.
- Valid/ready handshake on both sides lets the pipeline stall the EX stage cleanly.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- MUL_EN, 1: 1 enables the multi-cycle MUL; 0 makes the MUL funct illegal.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inValid  in  1  request present.
- inReady  out  1  block can accept; equals (state==IDLE) && (!outValid || outReady), combinational.
- ALUop  in  2  00 load/store, 01 branch, 10 R-type, 11 reserved.
- functionCode  in  4  R-type function field.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- outValid  out  1  result valid.
- outReady  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result==0).
- operation  out  4  registered decoded op code.
- illegal  out  1  registered: decode failed.
- busy  out  1  high while MUL is in progress.

Behaviour:
- Reset: outValid=0, result=0, zero=0, operation=0, illegal=0, busy=0, state=IDLE.
- Reset mid-MUL aborts the operation; no result is emitted.

Accept rule:
- Accept when inValid && inReady, on edge E.
- Output is consumed when outValid && outReady.
- Accept and consume may coincide on the same edge; the new result replaces the old with outValid staying 1.

Decode:
- ALUop 00 -> ADD (0010).
- ALUop 01 -> SUB (0110).
- ALUop 10 with functionCode:
  - 0000 ADD (0010)
  - 0010 SUB (0110)
  - 0100 AND (0000)
  - 0101 OR (0001)
  - 1010 SLT (0111)
  - 1001 SLL (1000)
  - 1011 SRL (1001)
  - 1000 MUL (1100), only if MUL_EN=1.
- ALUop 11, any other funct, or MUL with MUL_EN=0 -> operation=1111, illegal=1, result=0, zero=1.
  - Still completes in one cycle as a single-cycle op.

Arithmetic:
- All results are modulo 2^WIDTH; carries are dropped.
- SLT is a signed compare and yields 1 or 0.
- SLL/SRL shift a by b[$clog2(WIDTH)-1:0]; SRL is logical.
- MUL returns the low WIDTH bits of a*b.

Single-cycle ops:
- On edge E, result/zero/operation/illegal are registered and outValid=1.
- Latency is 1 clock.
- State remains IDLE.

State machine:
- IDLE:
  - accept of non-MUL -> IDLE, outValid=1.
  - accept of MUL -> MULT, with busy=1, multiplicand=a, multiplier=b, acc=0, count=WIDTH.
- MULT:
  - each edge: if multiplier[0], acc+=multiplicand; multiplicand<<=1; multiplier>>=1; count-=1.
  - when count reaches 0 (edge E+WIDTH): result=acc, zero, operation=1100, outValid=1, busy=0 -> IDLE.
  - inReady=0 throughout.
  - A MUL can only start when no output is pending (inReady rule), so completion never overwrites an unconsumed result.
- Hold: while outValid && !outReady, result/zero/operation/illegal are held stable and inReady=0.
- Consume without a new accept: outValid->0, and result/zero/operation/illegal keep their last values.
- inValid when inReady=0: ignored; inputs are not sampled.
- operation/illegal update only on completion, never combinationally.

Test Plan:
- Reset: rst=1 for 2 cycles with inValid=1 -> all outputs 0, inReady=1 after release.
- ALUop=10, funct=0010, a=7, b=7, outReady=1 -> one cycle later outValid=1, result=0, zero=1, operation=0110.
- ALUop=10, funct=1010, a=0xFFFFFFFF, b=1 -> result=1 (signed -1<1), operation=0111.
- ALUop=10, funct=1111; then ALUop=11 -> operation=1111, illegal=1, result=0, outValid=1 after 1 cycle each.
- WIDTH=8, MUL, a=13, b=11:
  - busy=1 for 8 cycles, inReady=0 throughout.
  - result=0x8F (143), outValid on edge E+8.
  - Repeat with rst pulsed at cycle 4 -> outValid never asserts, busy=0.
- Backpressure: outReady=0, ADD 3+4 -> result=7 held over 5 cycles and inReady=0.
  - Then outReady=1 with a new SUB 9-2 on the same edge -> outValid stays 1, result=7, operation=0110.

Source files
------------

// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU: decodes ALUop/functionCode, runs single-cycle ops in one clock
// and MUL as a WIDTH-step shift-add sequence, with valid/ready on both sides.
module alu_ctrl_exec #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [1:0]       ALUop,
    input  logic [3:0]       functionCode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       operation,
    output logic             illegal,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_ILL = 4'b1111;

    typedef enum logic {IDLE, MULT} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;

    logic [3:0]       dec_op;
    logic             dec_illegal;
    logic             dec_is_mul;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_next;
    logic             accept;
    logic             consume;

    assign inReady = (state == IDLE) && (!outValid || outReady);
    assign accept  = inValid && inReady;
    assign consume = outValid && outReady;
    assign shamt   = b[SHW-1:0];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        dec_op = OP_ILL;
        case (ALUop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (functionCode)
                    4'b0000: dec_op = OP_ADD;
                    4'b0010: dec_op = OP_SUB;
                    4'b0100: dec_op = OP_AND;
                    4'b0101: dec_op = OP_OR;
                    4'b1010: dec_op = OP_SLT;
                    4'b1001: dec_op = OP_SLL;
                    4'b1011: dec_op = OP_SRL;
                    4'b1000: dec_op = MUL_EN ? OP_MUL : OP_ILL;
                    default: dec_op = OP_ILL;
                endcase
            end
            default: dec_op = OP_ILL;
        endcase
        dec_illegal = (dec_op == OP_ILL);
        dec_is_mul  = (dec_op == OP_MUL);
    end

    // Illegal decodes fall through to zero, which also yields zero=1.
    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            default: alu_res = '0;
        endcase
    end

    assign acc_next = mplier[0] ? acc + mcand : acc;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            outValid  <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            operation <= '0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            if (consume) outValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_is_mul) begin
                            state  <= MULT;
                            busy   <= 1'b1;
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            count  <= CW'(WIDTH);
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            operation <= dec_op;
                            illegal   <= dec_illegal;
                            outValid  <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    // Last step: publish the accumulator including this edge's partial product.
                    if (count == CW'(1)) begin
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        operation <= OP_MUL;
                        illegal   <= 1'b0;
                        outValid  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
